// File: rtl/inst_issue_queue.sv
`default_nettype none
// inst_issue_queue: dual-lane fetch-to-decode circular buffer; up to 2 entries
// in and out per cycle, strict program order, flushed on redirect.
module inst_issue_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid_1,
  input  logic [31:0]   in_inst_1,
  input  logic [31:0]   in_pc_1,
  input  logic [1:0]    in_exc_1,
  input  logic          in_valid_2,
  input  logic [31:0]   in_inst_2,
  input  logic [31:0]   in_pc_2,
  input  logic [1:0]    in_exc_2,
  output logic          in_ready,
  output logic          out_valid_1,
  output logic [31:0]   out_inst_1,
  output logic [31:0]   out_pc_1,
  output logic [1:0]    out_exc_1,
  output logic          out_valid_2,
  output logic [31:0]   out_inst_2,
  output logic [31:0]   out_pc_2,
  output logic [1:0]    out_exc_2,
  input  logic [1:0]    out_accept,
  output logic [AW:0]   count,
  output logic          err_overflow
);

  localparam logic [AW:0] READY_MAX = (AW+1)'(DEPTH - 2);
  localparam logic [AW:0] ONE       = (AW+1)'(1);

  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];
  logic [1:0]    exc_mem  [DEPTH];

  logic [AW-1:0] head, tail;
  logic [AW-1:0] head_p1, tail_p1;
  logic [1:0]    enq_n, enq_eff, deq_n, acc;
  logic          enq_en;

  // Ready looks only at registered occupancy so no path runs from out_accept.
  assign in_ready = (count <= READY_MAX);
  assign enq_en   = in_ready && !flush;
  assign head_p1  = head + AW'(1);
  assign tail_p1  = tail + AW'(1);
  assign enq_n    = {1'b0, in_valid_1} + {1'b0, in_valid_2};
  assign enq_eff  = enq_en ? enq_n : 2'd0;

  always_comb begin
    acc = (out_accept == 2'd3) ? 2'd2 : out_accept;
    if (count == '0)
      deq_n = 2'd0;
    else if (count == ONE && acc != 2'd0)
      deq_n = 2'd1;
    else
      deq_n = acc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (!in_ready && (in_valid_1 || in_valid_2))
        err_overflow <= 1'b1;
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        head  <= head + AW'(deq_n);
        tail  <= tail + AW'(enq_eff);
        count <= count + (AW+1)'(enq_eff) - (AW+1)'(deq_n);
      end
    end
  end

  // A lane-2-only entry is packed into the tail slot, keeping entries contiguous.
  always_ff @(posedge clk) begin
    if (enq_en) begin
      if (in_valid_1 && in_valid_2) begin
        inst_mem[tail]    <= in_inst_1;
        pc_mem[tail]      <= in_pc_1;
        exc_mem[tail]     <= in_exc_1;
        inst_mem[tail_p1] <= in_inst_2;
        pc_mem[tail_p1]   <= in_pc_2;
        exc_mem[tail_p1]  <= in_exc_2;
      end else if (in_valid_1) begin
        inst_mem[tail] <= in_inst_1;
        pc_mem[tail]   <= in_pc_1;
        exc_mem[tail]  <= in_exc_1;
      end else if (in_valid_2) begin
        inst_mem[tail] <= in_inst_2;
        pc_mem[tail]   <= in_pc_2;
        exc_mem[tail]  <= in_exc_2;
      end
    end
  end

  assign out_valid_1 = (count != '0);
  assign out_valid_2 = (count > ONE);
  assign out_inst_1  = out_valid_1 ? inst_mem[head]    : 32'd0;
  assign out_pc_1    = out_valid_1 ? pc_mem[head]      : 32'd0;
  assign out_exc_1   = out_valid_1 ? exc_mem[head]     : 2'd0;
  assign out_inst_2  = out_valid_2 ? inst_mem[head_p1] : 32'd0;
  assign out_pc_2    = out_valid_2 ? pc_mem[head_p1]   : 32'd0;
  assign out_exc_2   = out_valid_2 ? exc_mem[head_p1]  : 2'd0;

endmodule
`default_nettype wire

// File: tb/tb_inst_issue_queue.sv
`default_nettype none
// tb_inst_issue_queue: directed plus random checks against a queue-based model.
module tb_inst_issue_queue;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [1:0]  exc;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid_1 = 1'b0, in_valid_2 = 1'b0;
  logic [31:0] in_inst_1 = '0, in_pc_1 = '0, in_inst_2 = '0, in_pc_2 = '0;
  logic [1:0]  in_exc_1 = '0, in_exc_2 = '0;
  logic [1:0]  out_accept = '0;
  logic        in_ready, out_valid_1, out_valid_2, err_overflow;
  logic [31:0] out_inst_1, out_pc_1, out_inst_2, out_pc_2;
  logic [1:0]  out_exc_1, out_exc_2;
  logic [AW:0] count;

  int   n_assert = 0;
  int   n_fail   = 0;
  ent_t q[$];
  logic m_err = 1'b0;
  logic [31:0] pc_seq = 32'h0000_1000;

  inst_issue_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid_1(in_valid_1), .in_inst_1(in_inst_1), .in_pc_1(in_pc_1), .in_exc_1(in_exc_1),
    .in_valid_2(in_valid_2), .in_inst_2(in_inst_2), .in_pc_2(in_pc_2), .in_exc_2(in_exc_2),
    .in_ready(in_ready),
    .out_valid_1(out_valid_1), .out_inst_1(out_inst_1), .out_pc_1(out_pc_1), .out_exc_1(out_exc_1),
    .out_valid_2(out_valid_2), .out_inst_2(out_inst_2), .out_pc_2(out_pc_2), .out_exc_2(out_exc_2),
    .out_accept(out_accept), .count(count), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int   n;
    ent_t e1, e2;
    n  = q.size();
    e1 = (n >= 1) ? q[0] : '0;
    e2 = (n >= 2) ? q[1] : '0;
    chk({tag, ":count"},    64'(count),        64'(n));
    chk({tag, ":in_ready"}, 64'(in_ready),     64'(n <= DEPTH - 2));
    chk({tag, ":valid_1"},  64'(out_valid_1),  64'(n >= 1));
    chk({tag, ":valid_2"},  64'(out_valid_2),  64'(n >= 2));
    chk({tag, ":inst_1"},   64'(out_inst_1),   64'(e1.inst));
    chk({tag, ":pc_1"},     64'(out_pc_1),     64'(e1.pc));
    chk({tag, ":exc_1"},    64'(out_exc_1),    64'(e1.exc));
    chk({tag, ":inst_2"},   64'(out_inst_2),   64'(e2.inst));
    chk({tag, ":pc_2"},     64'(out_pc_2),     64'(e2.pc));
    chk({tag, ":exc_2"},    64'(out_exc_2),    64'(e2.exc));
    chk({tag, ":err"},      64'(err_overflow), 64'(m_err));
  endtask

  task automatic set_in(input logic v1, input logic [31:0] i1, input logic [31:0] p1,
                        input logic [1:0] x1, input logic v2, input logic [31:0] i2,
                        input logic [31:0] p2, input logic [1:0] x2,
                        input logic [1:0] acc, input logic fl);
    in_valid_1 = v1; in_inst_1 = i1; in_pc_1 = p1; in_exc_1 = x1;
    in_valid_2 = v2; in_inst_2 = i2; in_pc_2 = p2; in_exc_2 = x2;
    out_accept = acc; flush = fl;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reference: decode takes min(accept, 2, occupancy) from the front, then fetch
  // appends valid lanes in lane order if there was room before the edge.
  task automatic tick(input string tag);
    bit rdy;
    int deq;
    rdy = (q.size() <= DEPTH - 2);
    if (!rdy && (in_valid_1 || in_valid_2)) m_err = 1'b1;
    if (flush) begin
      q.delete();
    end else begin
      deq = (int'(out_accept) > 2) ? 2 : int'(out_accept);
      if (deq > q.size()) deq = q.size();
      repeat (deq) void'(q.pop_front());
      if (rdy) begin
        if (in_valid_1) q.push_back('{in_inst_1, in_pc_1, in_exc_1});
        if (in_valid_2) q.push_back('{in_inst_2, in_pc_2, in_exc_2});
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic enq2(input string tag, input logic [1:0] acc);
    set_in(1, 32'h2400_0000 | pc_seq, pc_seq, pc_seq[3:2],
           1, 32'h2400_0000 | (pc_seq + 4), pc_seq + 4, pc_seq[3:2] + 2'd1, acc, 0);
    pc_seq = pc_seq + 8;
    tick(tag);
  endtask

  task automatic enq1(input string tag);
    set_in(1, 32'h2400_0000 | pc_seq, pc_seq, pc_seq[3:2], 0, 0, 0, 0, 0, 0);
    pc_seq = pc_seq + 4;
    tick(tag);
  endtask

  initial begin
    idle();
    #12;
    check_all("reset_init");
    reset = 1'b1;
    @(posedge clk); #1;

    // 1: asynchronous reset with five entries held
    enq2("t1_a", 0); enq2("t1_b", 0); enq1("t1_c");
    chk("t1_count5", 64'(count), 64'd5);
    #2;
    reset = 1'b0;
    #1;
    q.delete(); m_err = 1'b0;
    check_all("t1_async");
    chk("t1_inst_zero", 64'(out_inst_1), 64'd0);
    #2;
    reset = 1'b1;

    // 2: dual enqueue then dual dequeue
    set_in(1, 32'h2401_0001, 32'hbfc0_0000, 0, 1, 32'h2402_0002, 32'hbfc0_0004, 0, 0, 0);
    tick("t2_enq");
    chk("t2_count", 64'(count), 64'd2);
    chk("t2_inst1", 64'(out_inst_1), 64'h2401_0001);
    chk("t2_pc2",   64'(out_pc_2),   64'hbfc0_0004);
    idle(); out_accept = 2'd2;
    tick("t2_deq");
    chk("t2_empty", 64'(count), 64'd0);

    // 3: lane-2-only entry becomes the head
    set_in(0, 0, 0, 0, 1, 32'h2403_0003, 32'hbfc0_0010, 2'b10, 0, 0);
    tick("t3_enq");
    chk("t3_v1", 64'(out_valid_1), 64'd1);
    chk("t3_pc1", 64'(out_pc_1), 64'hbfc0_0010);
    chk("t3_v2", 64'(out_valid_2), 64'd0);
    idle(); out_accept = 2'd1;
    tick("t3_deq");

    // 4: fill past the wrap, overflow attempt, ordered drain
    pc_seq = 32'h0000_2000;
    enq2("t4_f0", 0); enq2("t4_f1", 0); enq2("t4_f2", 0);
    chk("t4_rdy6", 64'(in_ready), 64'd1);
    enq2("t4_f3", 0);
    chk("t4_full", 64'(count), 64'd8);
    chk("t4_nrdy", 64'(in_ready), 64'd0);
    enq2("t4_ovf", 0);
    chk("t4_err", 64'(err_overflow), 64'd1);
    chk("t4_cnt8", 64'(count), 64'd8);
    for (int i = 0; i < 4; i++) begin
      chk("t4_drain_pc1", 64'(out_pc_1), 64'(32'h2000 + 8 * i));
      chk("t4_drain_pc2", 64'(out_pc_2), 64'(32'h2004 + 8 * i));
      idle(); out_accept = 2'd2;
      tick("t4_drain");
    end

    // 5: flush beats simultaneous enqueue and dequeue
    enq2("t5_a", 0); enq1("t5_b");
    chk("t5_cnt3", 64'(count), 64'd3);
    set_in(1, 32'h1111_1111, 32'h0000_3000, 0, 1, 32'h2222_2222, 32'h0000_3004, 0, 2, 1);
    tick("t5_flush");
    chk("t5_zero", 64'(count), 64'd0);
    set_in(1, 32'h3333_3333, 32'h0000_4000, 1, 1, 32'h4444_4444, 32'h0000_4004, 2, 0, 0);
    tick("t5_after");
    chk("t5_pc1", 64'(out_pc_1), 64'h0000_4000);
    idle(); out_accept = 2'd2;
    tick("t5_clr");

    // 6: accept clamping
    enq1("t6_one");
    idle(); out_accept = 2'd2;
    tick("t6_clamp1");
    chk("t6_cnt0", 64'(count), 64'd0);
    enq2("t6_a", 0); enq2("t6_b", 0);
    idle(); out_accept = 2'd3;
    tick("t6_acc3");
    chk("t6_cnt2", 64'(count), 64'd2);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic v1, v2, fl;
      v1 = ($urandom_range(0, 2) != 0);
      v2 = ($urandom_range(0, 2) != 0);
      fl = ($urandom_range(0, 24) == 0);
      if (fl && q.size() > DEPTH - 2) begin v1 = 0; v2 = 0; end
      set_in(v1, $urandom, pc_seq, 2'($urandom), v2, $urandom, pc_seq + 4, 2'($urandom),
             2'($urandom_range(0, 3)), fl);
      pc_seq = pc_seq + 8;
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
